// File: rtl/nx1_opm_wrq_if.sv
// Host-side and OPM-side signal bundle for the X1 FM board OPM write scheduler.
// The scheduler uses the slave modport; the slot decode / test driver uses master.
interface nx1_opm_wrq_if #(
   parameter int P_DEPTH_LOG2 = 4
);
   logic                  host_cs;
   logic                  host_a0;
   logic                  host_wr;
   logic                  host_rd;
   logic [7:0]            host_wdata;
   logic [7:0]            host_rdata;
   logic                  opm_cke;
   logic [1:0]            opm_flags;
   logic [7:0]            opm_addr;
   logic [7:0]            opm_wdata;
   logic                  opm_we;
   logic [P_DEPTH_LOG2:0] wrq_level;

   modport slave (
      input  host_cs, host_a0, host_wr, host_rd, host_wdata, opm_cke, opm_flags,
      output host_rdata, opm_addr, opm_wdata, opm_we, wrq_level
   );

   modport master (
      output host_cs, host_a0, host_wr, host_rd, host_wdata, opm_cke, opm_flags,
      input  host_rdata, opm_addr, opm_wdata, opm_we, wrq_level
   );
endinterface

// File: rtl/nx1_opm_wrq.sv
// YM2151 (OPM) write scheduler: queues Z80 register writes and replays them paced to OPM recovery time.
// Optional sticky overflow flag in status bit6 when NX1_OPM_WRQ_OVF_EN is defined.
module nx1_opm_wrq #(
   parameter int P_DEPTH_LOG2 = 4,
   parameter int P_WAIT_CKE   = 64,
   parameter int P_CNT_W      = 7
) (
   input logic           slot_sysclk,
   input logic           slot_reset,
   nx1_opm_wrq_if.slave  bus
);

   localparam int                    DEPTH    = 2 ** P_DEPTH_LOG2;
   localparam logic [P_DEPTH_LOG2:0] FULL_LVL = (P_DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [P_CNT_W-1:0]    WAIT_LD  = P_CNT_W'(P_WAIT_CKE);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t                  state_q, state_d;
   logic [15:0]             mem [DEPTH];
   logic [P_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [P_DEPTH_LOG2:0]   level;
   logic [7:0]              addr_latch;
   logic [P_CNT_W-1:0]      cnt;
   logic [7:0]              rdata_q;
   logic [7:0]              opm_addr_q, opm_wdata_q;
   logic                    opm_we_q;

   logic wr_acc, rd_acc, data_wr, addr_wr;
   logic fifo_empty, fifo_full, pop, push_ok, busy, ovf_bit;

   // Level never wraps: a push is only accepted when a slot is free (or freed by this cycle's pop).
   function automatic logic [P_DEPTH_LOG2:0] next_level(
      input logic [P_DEPTH_LOG2:0] lvl,
      input logic                  inc,
      input logic                  dec
   );
      logic [P_DEPTH_LOG2:0] r;
      r = lvl;
      if (inc && !dec && lvl != FULL_LVL)
         r = lvl + 1'b1;
      else if (dec && !inc && lvl != '0)
         r = lvl - 1'b1;
      return r;
   endfunction

   assign wr_acc     = bus.host_cs & bus.host_wr;
   assign rd_acc     = bus.host_cs & bus.host_rd & ~bus.host_wr;
   assign data_wr    = wr_acc & bus.host_a0;
   assign addr_wr    = wr_acc & ~bus.host_a0;
   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == FULL_LVL);
   assign push_ok    = data_wr & (~fifo_full | pop);
   assign busy       = ~fifo_empty | (state_q != ST_IDLE);

   // The head is popped on the IDLE->ISSUE edge so opm_addr/opm_wdata/opm_we line up in the ISSUE cycle.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.opm_cke && cnt == P_CNT_W'(1))
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge slot_sysclk) begin
      if (slot_reset) begin
         state_q    <= ST_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         addr_latch <= '0;
         cnt        <= '0;
         rdata_q    <= '0;
         opm_addr_q <= '0;
         opm_wdata_q <= '0;
         opm_we_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         level    <= next_level(level, push_ok, pop);
         opm_we_q <= pop;
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            opm_addr_q  <= mem[rd_ptr][15:8];
            opm_wdata_q <= mem[rd_ptr][7:0];
         end
         if (addr_wr)
            addr_latch <= bus.host_wdata;
         if (state_q == ST_ISSUE)
            cnt <= WAIT_LD;
         else if (state_q == ST_WAIT && bus.opm_cke)
            cnt <= cnt - 1'b1;
         if (rd_acc)
            rdata_q <= {busy, ovf_bit, 4'b0000, bus.opm_flags};
      end
   end

   // Queue storage carries no reset; the pointers and level define what is valid.
   always_ff @(posedge slot_sysclk) begin
      if (push_ok)
         mem[wr_ptr] <= {addr_latch, bus.host_wdata};
   end

`ifdef NX1_OPM_WRQ_OVF_EN
   logic ovf_q;

   always_ff @(posedge slot_sysclk) begin
      if (slot_reset)
         ovf_q <= 1'b0;
      else if (data_wr && !push_ok)
         ovf_q <= 1'b1;
      else if (rd_acc)
         ovf_q <= 1'b0;
   end

   assign ovf_bit = ovf_q;
`else
   assign ovf_bit = 1'b0;
`endif

   assign bus.host_rdata = rdata_q;
   assign bus.opm_addr   = opm_addr_q;
   assign bus.opm_wdata  = opm_wdata_q;
   assign bus.opm_we     = opm_we_q;
   assign bus.wrq_level  = level;

endmodule

// File: tb/tb_nx1_opm_wrq.sv
// Bench for nx1_opm_wrq: directed scenarios followed by random traffic, checked every cycle
// against a transaction-level queue model of the OPM write scheduler.
module tb_nx1_opm_wrq;
   localparam int P_DEPTH_LOG2 = 4;
   localparam int P_WAIT_CKE   = 64;
   localparam int P_CNT_W      = 7;
   localparam int DEPTH        = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nx1_opm_wrq_if #(.P_DEPTH_LOG2(P_DEPTH_LOG2)) bus ();

   nx1_opm_wrq #(
      .P_DEPTH_LOG2(P_DEPTH_LOG2),
      .P_WAIT_CKE  (P_WAIT_CKE),
      .P_CNT_W     (P_CNT_W)
   ) dut (
      .slot_sysclk(clk),
      .slot_reset (rst),
      .bus        (bus)
   );

`ifdef NX1_OPM_WRQ_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: pending writes, recovery lock and status registers
   logic [15:0] q[$];
   logic [7:0]  m_latch, m_addr, m_wdata, m_rdata;
   bit          m_we, m_ovf, m_issue_cycle;
   int          m_lock_cke;

   int cyc, last_we_cyc, cke_since;
   bit have_last;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit r, cs, a0, wr, rd, input logic [7:0] wd,
                        input bit cke, input logic [1:0] fl);
      bit          idle, busy, over;
      logic [15:0] e;
      logic [7:0]  status;
      if (r) begin
         q.delete();
         m_latch = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
         m_we = 0; m_ovf = 0; m_issue_cycle = 0; m_lock_cke = 0;
         return;
      end
      idle   = !m_issue_cycle && (m_lock_cke == 0);
      busy   = (q.size() != 0) || !idle;
      status = {busy, (OVF_EN ? m_ovf : 1'b0), 4'b0000, fl};
      over   = 0;
      // After each strobe: one clock, then P_WAIT_CKE cke strobes before the next may go
      if (m_issue_cycle) begin
         m_issue_cycle = 0;
         m_lock_cke    = P_WAIT_CKE;
      end else if (m_lock_cke > 0 && cke) begin
         m_lock_cke--;
      end
      m_we = 0;
      if (idle && q.size() > 0) begin
         e             = q.pop_front();
         m_addr        = e[15:8];
         m_wdata       = e[7:0];
         m_we          = 1;
         m_issue_cycle = 1;
      end
      if (cs && wr && a0) begin
         if (q.size() < DEPTH) q.push_back({m_latch, wd});
         else over = 1;
      end
      if (cs && wr && !a0) m_latch = wd;
      if (cs && rd && !wr) begin
         m_rdata = status;
         m_ovf   = 0;
      end
      if (over) m_ovf = 1;
   endtask

   task automatic step(input bit r, cs, a0, wr, rd, input logic [7:0] wd,
                       input bit cke, input logic [1:0] fl);
      rst            = r;
      bus.host_cs    = cs;
      bus.host_a0    = a0;
      bus.host_wr    = wr;
      bus.host_rd    = rd;
      bus.host_wdata = wd;
      bus.opm_cke    = cke;
      bus.opm_flags  = fl;
      @(posedge clk);
      model(r, cs, a0, wr, rd, wd, cke, fl);
      cyc++;
      #1;
      check("opm_we", 16'(bus.opm_we), 16'(m_we));
      check("opm_addr", 16'(bus.opm_addr), 16'(m_addr));
      check("opm_wdata", 16'(bus.opm_wdata), 16'(m_wdata));
      check("wrq_level", 16'(bus.wrq_level), 16'(q.size()));
      check("host_rdata", 16'(bus.host_rdata), 16'(m_rdata));
      if (r) begin
         have_last = 0;
      end else if (bus.opm_we) begin
         if (have_last) begin
            check("spacing_cke", 16'(cke_since >= P_WAIT_CKE), 16'd1);
            check("spacing_clk", 16'(cyc - last_we_cyc >= P_WAIT_CKE + 2), 16'd1);
         end
         have_last   = 1;
         last_we_cyc = cyc;
         cke_since   = 0;
      end else begin
         cke_since += int'(cke);
      end
   endtask

   task automatic idle(input int n, input bit cke, input logic [1:0] fl);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00, cke, fl);
   endtask

   task automatic wr_addr(input logic [7:0] v, input bit cke);
      step(0, 1, 0, 1, 0, v, cke, 2'b00);
   endtask

   task automatic wr_data(input logic [7:0] v, input bit cke);
      step(0, 1, 1, 1, 0, v, cke, 2'b00);
   endtask

   task automatic rd_status(input logic [1:0] fl, input bit cke);
      step(0, 1, $urandom_range(0, 1) == 1, 0, 1, 8'h00, cke, fl);
   endtask

   initial begin
      cyc = 0; last_we_cyc = 0; cke_since = 0; have_last = 0;
      model(1, 0, 0, 0, 0, 8'h00, 0, 2'b00);

      // Reset, then status read
      step(1, 0, 0, 0, 0, 8'h00, 1, 2'b00);
      step(1, 0, 0, 0, 0, 8'h00, 1, 2'b00);
      idle(2, 1, 2'b00);
      rd_status(2'b00, 1);
      idle(1, 1, 2'b00);
      check("reset_status", 16'(bus.host_rdata), 16'h00);

      // Single write 20h/C7h: strobe two clocks after the data write
      wr_addr(8'h20, 1);
      wr_data(8'hC7, 1);
      check("lat_c1_we", 16'(bus.opm_we), 16'd0);
      rd_status(2'b00, 1);
      check("lat_c2_we", 16'(bus.opm_we), 16'd1);
      check("lat_c2_addr", 16'(bus.opm_addr), 16'h20);
      check("lat_c2_data", 16'(bus.opm_wdata), 16'hC7);
      check("busy_after_push", 16'(bus.host_rdata[7]), 16'd1);
      idle(P_WAIT_CKE + 4, 1, 2'b00);
      rd_status(2'b00, 1);
      check("busy_cleared", 16'(bus.host_rdata[7]), 16'd0);

      // Three data writes behind one address write
      wr_addr(8'h08, 1);
      wr_data(8'h00, 1);
      wr_data(8'h01, 1);
      wr_data(8'h02, 1);
      idle(3 * (P_WAIT_CKE + 2) + 8, 1, 2'b00);
      check("seq_last_addr", 16'(bus.opm_addr), 16'h08);
      check("seq_last_data", 16'(bus.opm_wdata), 16'h02);

      // Fill with cke stopped: one entry stuck in recovery, then 17 more pushes
      wr_addr(8'h30, 0);
      wr_data(8'hAA, 0);
      idle(3, 0, 2'b00);
      for (int i = 0; i < DEPTH + 1; i++) wr_data(8'(8'h40 + i), 0);
      check("full_level", 16'(bus.wrq_level), 16'(DEPTH));
      rd_status(2'b01, 0);
      check("full_status", 16'(bus.host_rdata), OVF_EN ? 16'hC1 : 16'h81);
      rd_status(2'b01, 0);
      check("ovf_cleared", 16'(bus.host_rdata[6]), 16'd0);

      // Reset while waiting with a queue pending
      idle(5, 1, 2'b00);
      step(1, 0, 0, 0, 0, 8'h00, 1, 2'b00);
      check("rst_level", 16'(bus.wrq_level), 16'd0);
      check("rst_we", 16'(bus.opm_we), 16'd0);
      rd_status(2'b00, 1);
      check("rst_busy", 16'(bus.host_rdata[7]), 16'd0);
      idle(P_WAIT_CKE + 10, 1, 2'b00);

      // Timer flags with an empty queue
      rd_status(2'b10, 1);
      check("flags_status", 16'(bus.host_rdata), 16'h02);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 999) == 0,
              $urandom_range(0, 7) != 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0,
              8'($urandom),
              $urandom_range(0, 2) != 0,
              2'($urandom));
      end
      idle(DEPTH * (P_WAIT_CKE + 2) + 20, 1, 2'b00);
      check("drain_level", 16'(bus.wrq_level), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
